// File: rtl/gbus_host_ctrl.sv
// gbus_host_ctrl: host-side GBUS initiator.
// Converts burst write/read commands to one head/column into registered GBUS drive.
// Read returns are collected into a credit-protected first-word-fall-through response FIFO.
// Ports:
//   clk, rstn                  clock, asynchronous active-low reset
//   cmd_*                      command channel (valid/ready, write, head, col, addr, len)
//   wr_valid/wr_ready/wr_data  write-beat channel
//   rsp_valid/rsp_ready/rsp_data  read-response channel
//   busy, err_unexp            activity flag, sticky unexpected-return flag
//   in_GBUS_ADDR, gbus_wen, gbus_wdata, gbus_ren  registered GBUS drive
//   gbus_rdata, gbus_rvalid    GBUS read returns
module gbus_host_ctrl #(
   parameter int unsigned HNUM      = 8,
   parameter int unsigned VNUM      = 8,
   parameter int unsigned GBUS_DATA = 64,
   parameter int unsigned GBUS_ADDR = 12,
   parameter int unsigned LEN_BIT   = 8,
   parameter int unsigned RSP_DEPTH = 4,
   localparam int unsigned HW = (HNUM > 1) ? $clog2(HNUM) : 1,
   localparam int unsigned VW = (VNUM > 1) ? $clog2(VNUM) : 1
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic                      cmd_write,
   input  logic [HW-1:0]             cmd_head,
   input  logic [VW-1:0]             cmd_col,
   input  logic [GBUS_ADDR-1:0]      cmd_addr,
   input  logic [LEN_BIT-1:0]        cmd_len,
   input  logic                      wr_valid,
   output logic                      wr_ready,
   input  logic [GBUS_DATA-1:0]      wr_data,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [GBUS_DATA-1:0]      rsp_data,
   output logic                      busy,
   output logic                      err_unexp,
   output logic [HNUM*GBUS_ADDR-1:0] in_GBUS_ADDR,
   output logic [HNUM*VNUM-1:0]      gbus_wen,
   output logic [HNUM*GBUS_DATA-1:0] gbus_wdata,
   output logic [HNUM*VNUM-1:0]      gbus_ren,
   input  logic [HNUM*GBUS_DATA-1:0] gbus_rdata,
   input  logic [HNUM*VNUM-1:0]      gbus_rvalid
);

   localparam int unsigned PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
   localparam int unsigned CW = PW + 1;
   localparam logic [CW:0] DepthC = (CW+1)'(RSP_DEPTH);

   typedef enum logic [1:0] {StIdle, StWrite, StRead, StDrain} state_e;

   state_e state_q, state_d;

   logic [HW-1:0]        head_q, head_d;
   logic [VW-1:0]        col_q, col_d;
   logic [GBUS_ADDR-1:0] addr_q, addr_d;
   logic [LEN_BIT-1:0]   rem_q, rem_d;
   logic [CW-1:0]        outst_q, outst_d;
   logic                 err_q, err_d;

   logic [GBUS_DATA-1:0] mem_q [RSP_DEPTH];
   logic [PW-1:0]        wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CW-1:0]        cnt_q, cnt_d;

   logic [HNUM*VNUM-1:0]      wen_q, wen_d, ren_q, ren_d;
   logic [HNUM*GBUS_ADDR-1:0] baddr_q, baddr_d;
   logic [HNUM*GBUS_DATA-1:0] wdata_q, wdata_d;

   logic                 wr_fire, rd_issue, credit;
   logic                 sel_rvalid, capture, push, pop;
   logic [GBUS_DATA-1:0] sel_rdata;
   logic [CW:0]          inflight;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state_q <= StIdle;
      else       state_q <= state_d;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (cmd_valid) state_d = cmd_write ? StWrite : StRead;
         StWrite: if (wr_fire && rem_q == '0) state_d = StIdle;
         StRead:  if (rd_issue && rem_q == '0) state_d = StDrain;
         StDrain: if (outst_q == '0) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   // Credit counts both reads in flight and buffered responses, so the FIFO never overflows.
   assign inflight = {1'b0, outst_q} + {1'b0, cnt_q};
   assign credit   = inflight < DepthC;

   always_comb begin
      cmd_ready = (state_q == StIdle);
      wr_ready  = (state_q == StWrite);
      rd_issue  = (state_q == StRead) && credit;
      wr_fire   = wr_ready && wr_valid;
      busy      = (state_q != StIdle) || (outst_q != '0);
   end

   // ---------------- Return selection ----------------
   always_comb begin
      sel_rvalid = 1'b0;
      sel_rdata  = '0;
      for (int unsigned h = 0; h < HNUM; h++) begin
         if (head_q == HW'(h)) begin
            sel_rdata = gbus_rdata[h*GBUS_DATA +: GBUS_DATA];
            for (int unsigned v = 0; v < VNUM; v++) begin
               if (col_q == VW'(v)) sel_rvalid = gbus_rvalid[h*VNUM + v];
            end
         end
      end
   end

   assign capture = sel_rvalid && (outst_q != '0);
   assign push    = capture;
   assign pop     = rsp_valid && rsp_ready;

   // ---------------- Datapath next state ----------------
   always_comb begin
      head_d  = head_q;
      col_d   = col_q;
      addr_d  = addr_q;
      rem_d   = rem_q;
      outst_d = outst_q;
      err_d   = err_q || (sel_rvalid && (outst_q == '0));
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      cnt_d   = cnt_q;

      if (cmd_ready && cmd_valid) begin
         head_d = cmd_head;
         col_d  = cmd_col;
         addr_d = cmd_addr;
         rem_d  = cmd_len;
      end else if (wr_fire || rd_issue) begin
         addr_d = addr_q + GBUS_ADDR'(1);
         rem_d  = rem_q - LEN_BIT'(1);
      end

      // Simultaneous issue and capture cancel out.
      if (rd_issue && !capture)      outst_d = outst_q + CW'(1);
      else if (!rd_issue && capture) outst_d = outst_q - CW'(1);

      if (push) wptr_d = wptr_q + PW'(1);
      if (pop)  rptr_d = rptr_q + PW'(1);
      if (push && !pop)      cnt_d = cnt_q + CW'(1);
      else if (!push && pop) cnt_d = cnt_q - CW'(1);
   end

   // ---------------- Bus drive next state ----------------
   // Only the selected head row carries address/data; idle cycles drive zeros.
   always_comb begin
      wen_d   = '0;
      ren_d   = '0;
      baddr_d = '0;
      wdata_d = '0;
      for (int unsigned h = 0; h < HNUM; h++) begin
         if (head_q == HW'(h)) begin
            if (wr_fire || rd_issue) baddr_d[h*GBUS_ADDR +: GBUS_ADDR] = addr_q;
            if (wr_fire)             wdata_d[h*GBUS_DATA +: GBUS_DATA] = wr_data;
            for (int unsigned v = 0; v < VNUM; v++) begin
               if (col_q == VW'(v)) begin
                  wen_d[h*VNUM + v] = wr_fire;
                  ren_d[h*VNUM + v] = rd_issue;
               end
            end
         end
      end
   end

   // ---------------- Registers ----------------
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         head_q  <= '0;
         col_q   <= '0;
         addr_q  <= '0;
         rem_q   <= '0;
         outst_q <= '0;
         err_q   <= 1'b0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         cnt_q   <= '0;
         wen_q   <= '0;
         ren_q   <= '0;
         baddr_q <= '0;
         wdata_q <= '0;
      end else begin
         head_q  <= head_d;
         col_q   <= col_d;
         addr_q  <= addr_d;
         rem_q   <= rem_d;
         outst_q <= outst_d;
         err_q   <= err_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         cnt_q   <= cnt_d;
         wen_q   <= wen_d;
         ren_q   <= ren_d;
         baddr_q <= baddr_d;
         wdata_q <= wdata_d;
      end
   end

   // FIFO storage needs no reset; validity is tracked by cnt_q.
   always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q] <= sel_rdata;
   end

   assign rsp_valid    = (cnt_q != '0);
   assign rsp_data     = mem_q[rptr_q];
   assign err_unexp    = err_q;
   assign in_GBUS_ADDR = baddr_q;
   assign gbus_wen     = wen_q;
   assign gbus_ren     = ren_q;
   assign gbus_wdata   = wdata_q;

endmodule

// File: tb/tb_gbus_host_ctrl.sv
module tb_gbus_host_ctrl;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
   logic [2:0]    cmd_head = '0, cmd_col = '0;
   logic [11:0]   cmd_addr = '0;
   logic [7:0]    cmd_len = '0;
   logic          wr_valid = 1'b0, wr_ready;
   logic [63:0]   wr_data = '0;
   logic          rsp_valid, rsp_ready = 1'b0;
   logic [63:0]   rsp_data;
   logic          busy, err_unexp;
   logic [95:0]   in_GBUS_ADDR;
   logic [63:0]   gbus_wen, gbus_ren;
   logic [511:0]  gbus_wdata;
   logic [511:0]  gbus_rdata = '0;
   logic [63:0]   gbus_rvalid = '0;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   gbus_host_ctrl dut (
      .clk          (clk),
      .rstn         (rstn),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_write    (cmd_write),
      .cmd_head     (cmd_head),
      .cmd_col      (cmd_col),
      .cmd_addr     (cmd_addr),
      .cmd_len      (cmd_len),
      .wr_valid     (wr_valid),
      .wr_ready     (wr_ready),
      .wr_data      (wr_data),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_data     (rsp_data),
      .busy         (busy),
      .err_unexp    (err_unexp),
      .in_GBUS_ADDR (in_GBUS_ADDR),
      .gbus_wen     (gbus_wen),
      .gbus_wdata   (gbus_wdata),
      .gbus_ren     (gbus_ren),
      .gbus_rdata   (gbus_rdata),
      .gbus_rvalid  (gbus_rvalid)
   );

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_cmd_ready"}, cmd_ready, 1);
      check({tag, "_wr_ready"}, wr_ready, 0);
      check({tag, "_rsp_valid"}, rsp_valid, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_err"}, err_unexp, 0);
      check({tag, "_bus"}, {gbus_wen, gbus_ren, in_GBUS_ADDR}, 0);
      check({tag, "_wdata"}, gbus_wdata, 0);
   endtask

   task automatic send_cmd(input logic w, input int h, input int c, input logic [11:0] a,
                           input int len);
      @(negedge clk);
      cmd_valid = 1'b1; cmd_write = w; cmd_head = 3'(h); cmd_col = 3'(c);
      cmd_addr = a; cmd_len = 8'(len);
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   // gap != 0 toggles wr_valid 1,0,1,0,...
   task automatic run_write(input int h, input int c, input logic [11:0] a0, input int len,
                            input logic [63:0] d0, input int gap);
      logic [63:0]  bitv;
      logic [11:0]  a;
      logic         v;
      int           beats, i;
      bitv = 64'h1 << (h*8 + c);
      a = a0; beats = 0; i = 0;
      send_cmd(1'b1, h, c, a0, len);
      check("wr_ready_in_write", wr_ready, 1);
      while (beats <= len && i < 100) begin
         v = (gap == 0) || (i % 2 == 0);
         wr_valid = v; wr_data = d0 + 64'(beats);
         @(negedge clk);
         if (v) begin
            check("wr_wen", gbus_wen, bitv);
            check("wr_addr", in_GBUS_ADDR, {84'b0, a} << (h*12));
            check("wr_wdata", gbus_wdata, {448'b0, d0 + 64'(beats)} << (h*64));
            a = a + 12'd1; beats++;
         end else begin
            check("wr_gap_wen", gbus_wen, 0);
            check("wr_gap_addr", in_GBUS_ADDR, 0);
            check("wr_gap_wdata", gbus_wdata, 0);
         end
         i++;
      end
      wr_valid = 1'b0;
      check("wr_back_idle", cmd_ready, 1);
      @(negedge clk);
      check("wr_after_wen", gbus_wen, 0);
   endtask

   // Core model: returns arrive lat cycles after ren; rsp_ready held low until hold cycles.
   task automatic run_read(input int h, input int c, input logic [11:0] a0, input int len,
                           input int lat, input int hold);
      logic [63:0] bitv, tmp;
      logic [11:0] ea;
      int          issued, got, cyc;
      int          due_q[$];
      logic [63:0] dat_q[$];
      logic [63:0] exp_q[$];
      bitv = 64'h1 << (h*8 + c);
      ea = a0; issued = 0; got = 0; cyc = 0;
      rsp_ready = (hold == 0);
      send_cmd(1'b0, h, c, a0, len);
      while (cyc < 300 && !(got == len + 1 && !busy)) begin
         if (gbus_ren != 0) begin
            check("rd_ren", gbus_ren, bitv);
            check("rd_addr", in_GBUS_ADDR, {84'b0, ea} << (h*12));
            check("rd_no_wen", gbus_wen, 0);
            tmp = {16'hC0DE, 16'(issued), 20'h0, ea};
            due_q.push_back(cyc + lat); dat_q.push_back(tmp); exp_q.push_back(tmp);
            ea = ea + 12'd1; issued++;
         end
         if (hold > 0 && cyc == hold) begin
            check("rd_stall_issue_count", issued, 4);
            rsp_ready = 1'b1;
         end
         if (rsp_valid && rsp_ready) begin
            if (exp_q.size() > 0) check("rd_rsp_data", rsp_data, exp_q.pop_front());
            else check("rd_rsp_extra", rsp_data, 0);
            got++;
         end
         gbus_rvalid = '0;
         gbus_rdata  = {8{64'hBAD0_BAD0_BAD0_BAD0}};
         if (due_q.size() > 0 && due_q[0] == cyc) begin
            gbus_rvalid = bitv;
            gbus_rdata[h*64 +: 64] = dat_q.pop_front();
            void'(due_q.pop_front());
         end
         @(negedge clk);
         cyc++;
      end
      gbus_rvalid = '0;
      rsp_ready = 1'b0;
      check("rd_issue_count", issued, len + 1);
      check("rd_rsp_count", got, len + 1);
      check("rd_busy_dropped", busy, 0);
   endtask

   typedef struct {
      logic        wr;
      int          head;
      int          col;
      logic [11:0] addr;
      logic [63:0] data;
      logic [63:0] exp_vec;
      logic [95:0] exp_addr;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int          seen;
      logic [511:0] ew;

      vecs[0] = '{1'b1, 0, 0, 12'h123, 64'h1111_2222_3333_4444, 64'h1, 96'h123};
      vecs[1] = '{1'b1, 7, 7, 12'hABC, 64'hFEED_FACE_0000_0007, 64'h8000_0000_0000_0000,
                  96'habc_000000000000000000000};
      vecs[2] = '{1'b1, 3, 2, 12'h5A5, 64'h0123_4567_89AB_CDEF, 64'h0000_0000_0400_0000,
                  96'h5a5_000000000};
      vecs[3] = '{1'b0, 1, 6, 12'h0FF, 64'hAAAA_5555_AAAA_5555, 64'h4000, 96'h0ff_000};
      vecs[4] = '{1'b0, 4, 3, 12'h800, 64'h0F0F_0F0F_F0F0_F0F0, 64'h8_0000_0000,
                  96'h800_000000000000};
      vecs[5] = '{1'b0, 6, 0, 12'hFFF, 64'h1357_9BDF_2468_ACE0, 64'h1_0000_0000_0000,
                  96'hfff_000000000000000000};

      // Reset state
      repeat (3) @(negedge clk);
      check_reset_values("reset");
      rstn = 1'b1;

      // Single-beat table
      for (int i = 0; i < 6; i++) begin
         send_cmd(vecs[i].wr, vecs[i].head, vecs[i].col, vecs[i].addr, 0);
         if (vecs[i].wr) begin
            wr_valid = 1'b1; wr_data = vecs[i].data;
            @(negedge clk);
            wr_valid = 1'b0;
            ew = {448'b0, vecs[i].data} << (vecs[i].head*64);
            check("tbl_wen", gbus_wen, vecs[i].exp_vec);
            check("tbl_wr_ren", gbus_ren, 0);
            check("tbl_wr_addr", in_GBUS_ADDR, vecs[i].exp_addr);
            check("tbl_wdata", gbus_wdata, ew);
            check("tbl_wr_idle", cmd_ready, 1);
         end else begin
            @(negedge clk);
            check("tbl_ren", gbus_ren, vecs[i].exp_vec);
            check("tbl_rd_wen", gbus_wen, 0);
            check("tbl_rd_addr", in_GBUS_ADDR, vecs[i].exp_addr);
            check("tbl_rd_busy", busy, 1);
            gbus_rvalid = vecs[i].exp_vec;
            gbus_rdata  = {8{64'hDEAD_BEEF_DEAD_BEEF}};
            gbus_rdata[vecs[i].head*64 +: 64] = vecs[i].data;
            @(negedge clk);
            gbus_rvalid = '0;
            check("tbl_rsp_valid", rsp_valid, 1);
            check("tbl_rsp_data", rsp_data, vecs[i].data);
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
            check("tbl_rsp_popped", rsp_valid, 0);
            check("tbl_rd_done", busy, 0);
         end
      end

      // Burst write back-to-back
      run_write(2, 5, 12'h010, 3, 64'hA0, 0);
      // Read burst with address wrap, latency 3
      run_read(0, 1, 12'hFFE, 3, 3, 0);
      // Credit stall with rsp_ready low
      run_read(5, 2, 12'h400, 7, 3, 20);
      // Write with gaps
      run_write(6, 3, 12'h7F0, 3, 64'h5000, 1);
      // Read with single-cycle latency
      run_read(7, 4, 12'h020, 5, 1, 0);

      // Unexpected return
      @(negedge clk);
      gbus_rvalid = '1;
      gbus_rdata  = {8{64'h1234_5678_9ABC_DEF0}};
      @(negedge clk);
      gbus_rvalid = '0;
      check("unexp_no_push", rsp_valid, 0);
      check("unexp_err_set", err_unexp, 1);
      repeat (5) @(negedge clk);
      check("unexp_err_sticky", err_unexp, 1);
      #2 rstn = 1'b0;
      #1 check("unexp_err_cleared", err_unexp, 0);
      @(negedge clk);
      rstn = 1'b1;

      // Asynchronous reset mid-read with two reads outstanding
      send_cmd(1'b0, 3, 4, 12'h300, 7);
      seen = 0;
      for (int k = 0; k < 20 && seen < 2; k++) begin
         if (gbus_ren != 0) seen++;
         if (seen < 2) @(negedge clk);
      end
      check("mid_two_issued", seen, 2);
      check("mid_busy", busy, 1);
      #2 rstn = 1'b0;
      #1 check_reset_values("async_reset");
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      gbus_rvalid = '1;
      @(negedge clk);
      gbus_rvalid = '0;
      check("late_rvalid_err", err_unexp, 1);
      check("late_rvalid_no_push", rsp_valid, 0);
      run_write(1, 1, 12'h0AA, 0, 64'h77, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
